// File: rtl/fft16_sequencer_pkg.sv
// Shared constants, state encoding and address helpers for the 16-point FFT sequencer.
package fft16_sequencer_pkg;

  localparam int unsigned FftSize   = 16;
  localparam int unsigned FftStages = 4;

  localparam logic [2:0] StLoad    = 3'd0;
  localparam logic [2:0] StPresent = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StWrite   = 3'd3;
  localparam logic [2:0] StUnload  = 3'd4;

  function automatic logic [3:0] bitrev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

endpackage

// File: rtl/fft16_sequencer_if.sv
// Load, butterfly and unload signal bundle of the FFT sequencer.
interface fft16_sequencer_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                 i_load_valid;
    logic [WORD_SIZE-1:0] i_load_re;
    logic [WORD_SIZE-1:0] i_load_im;
    logic                 o_load_ready;

    logic [WORD_SIZE-1:0] o_bf_in0_re;
    logic [WORD_SIZE-1:0] o_bf_in0_im;
    logic [WORD_SIZE-1:0] o_bf_in1_re;
    logic [WORD_SIZE-1:0] o_bf_in1_im;
    logic [WORD_SIZE-1:0] o_bf_tw_re;
    logic [WORD_SIZE-1:0] o_bf_tw_im;

    logic                 i_bf_done;
    logic [WORD_SIZE-1:0] i_bf_out0_re;
    logic [WORD_SIZE-1:0] i_bf_out0_im;
    logic [WORD_SIZE-1:0] i_bf_out1_re;
    logic [WORD_SIZE-1:0] i_bf_out1_im;

    logic                 o_out_valid;
    logic                 i_out_ready;
    logic [WORD_SIZE-1:0] o_out_re;
    logic [WORD_SIZE-1:0] o_out_im;
    logic [3:0]           o_out_index;

    logic                 o_busy;

    modport slave (
        input  i_load_valid, i_load_re, i_load_im,
        output o_load_ready,
        output o_bf_in0_re, o_bf_in0_im, o_bf_in1_re, o_bf_in1_im, o_bf_tw_re, o_bf_tw_im,
        input  i_bf_done, i_bf_out0_re, i_bf_out0_im, i_bf_out1_re, i_bf_out1_im,
        output o_out_valid, o_out_re, o_out_im, o_out_index,
        input  i_out_ready,
        output o_busy
    );

    modport master (
        output i_load_valid, i_load_re, i_load_im,
        input  o_load_ready,
        input  o_bf_in0_re, o_bf_in0_im, o_bf_in1_re, o_bf_in1_im, o_bf_tw_re, o_bf_tw_im,
        output i_bf_done, i_bf_out0_re, i_bf_out0_im, i_bf_out1_re, i_bf_out1_im,
        input  o_out_valid, o_out_re, o_out_im, o_out_index,
        output i_out_ready,
        input  o_busy
    );
endinterface

// File: rtl/twiddle_rom16.sv
// Combinational W16^k table (k = 0..7) in Q(FRACTION); FRACTION must be 1..16.
module twiddle_rom16 #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned FRACTION  = 8
) (
    input  logic [2:0]           k_i,
    output logic [WORD_SIZE-1:0] re_o,
    output logic [WORD_SIZE-1:0] im_o
);
    // Round-to-nearest from Q16 reference constants down to Q(FRACTION).
    function automatic int q_round(input int q16);
        if (FRACTION >= 16) return q16;
        return (q16 + (1 <<< (15 - FRACTION))) >>> (16 - FRACTION);
    endfunction

    localparam int C0 = q_round(65536);  // cos 0
    localparam int C1 = q_round(60547);  // cos pi/8
    localparam int C2 = q_round(46341);  // cos pi/4
    localparam int C3 = q_round(25080);  // cos 3pi/8

    localparam logic [WORD_SIZE-1:0] P0 = WORD_SIZE'(C0);
    localparam logic [WORD_SIZE-1:0] P1 = WORD_SIZE'(C1);
    localparam logic [WORD_SIZE-1:0] P2 = WORD_SIZE'(C2);
    localparam logic [WORD_SIZE-1:0] P3 = WORD_SIZE'(C3);
    localparam logic [WORD_SIZE-1:0] N0 = WORD_SIZE'(-C0);
    localparam logic [WORD_SIZE-1:0] N1 = WORD_SIZE'(-C1);
    localparam logic [WORD_SIZE-1:0] N2 = WORD_SIZE'(-C2);
    localparam logic [WORD_SIZE-1:0] N3 = WORD_SIZE'(-C3);

    always_comb begin
        re_o = '0;
        im_o = '0;
        case (k_i)
            3'd0: begin re_o = P0; im_o = '0; end
            3'd1: begin re_o = P1; im_o = N3; end
            3'd2: begin re_o = P2; im_o = N2; end
            3'd3: begin re_o = P3; im_o = N1; end
            3'd4: begin re_o = '0; im_o = N0; end
            3'd5: begin re_o = N3; im_o = N1; end
            3'd6: begin re_o = N2; im_o = N2; end
            default: begin re_o = N1; im_o = N3; end
        endcase
    end
endmodule

// File: rtl/fft16_sequencer.sv
// Sequences an in-place radix-2 DIT 16-point FFT over an external butterfly unit:
// bit-reversed load, 32 butterfly round-trips, natural-order unload.
module fft16_sequencer
    import fft16_sequencer_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned FRACTION  = 8
) (
    input logic              i_clk,
    input logic              i_rst,
    fft16_sequencer_if.slave bus_io
);
    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;  // load counter in LOAD, unload counter in UNLOAD
    logic [1:0] stage_q, stage_d;
    logic [2:0] bfly_q, bfly_d;

    logic [WORD_SIZE-1:0] bank_re [FftSize];
    logic [WORD_SIZE-1:0] bank_im [FftSize];

    logic [WORD_SIZE-1:0] in0_re_q, in0_im_q, in1_re_q, in1_im_q, tw_re_q, tw_im_q;
    logic [WORD_SIZE-1:0] res0_re_q, res0_im_q, res1_re_q, res1_im_q;
    logic [WORD_SIZE-1:0] tw_re, tw_im;

    logic [3:0] span, idx0, idx1;
    logic [2:0] low, tw_k;

    always_comb begin
        span = 4'd1 << stage_q;
        low  = bfly_q & 3'(span - 4'd1);
        idx0 = ((4'(bfly_q) >> stage_q) << ({1'b0, stage_q} + 3'd1)) | 4'(low);
        idx1 = idx0 + span;
        tw_k = low << (2'd3 - stage_q);
    end

    twiddle_rom16 #(
        .WORD_SIZE(WORD_SIZE),
        .FRACTION (FRACTION)
    ) u_twiddle_rom16 (
        .k_i (tw_k),
        .re_o(tw_re),
        .im_o(tw_im)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        case (state_q)
            StLoad: begin
                if (bus_io.i_load_valid) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(FftSize - 1)) begin
                        state_d = StPresent;
                        stage_d = '0;
                        bfly_d  = '0;
                    end
                end
            end
            StPresent: state_d = StWait;
            StWait: if (bus_io.i_bf_done) state_d = StWrite;
            StWrite: begin
                bfly_d  = bfly_q + 3'd1;
                state_d = StPresent;
                if (bfly_q == 3'd7) begin
                    stage_d = stage_q + 2'd1;
                    if (stage_q == 2'(FftStages - 1)) begin
                        state_d = StUnload;
                        cnt_d   = '0;
                    end
                end
            end
            StUnload: begin
                if (bus_io.i_out_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(FftSize - 1)) state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= StLoad;
            cnt_q     <= '0;
            stage_q   <= '0;
            bfly_q    <= '0;
            in0_re_q  <= '0;
            in0_im_q  <= '0;
            in1_re_q  <= '0;
            in1_im_q  <= '0;
            tw_re_q   <= '0;
            tw_im_q   <= '0;
            res0_re_q <= '0;
            res0_im_q <= '0;
            res1_re_q <= '0;
            res1_im_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            if (state_q == StPresent) begin
                in0_re_q <= bank_re[idx0];
                in0_im_q <= bank_im[idx0];
                in1_re_q <= bank_re[idx1];
                in1_im_q <= bank_im[idx1];
                tw_re_q  <= tw_re;
                tw_im_q  <= tw_im;
            end
            if (state_q == StWait && bus_io.i_bf_done) begin
                res0_re_q <= bus_io.i_bf_out0_re;
                res0_im_q <= bus_io.i_bf_out0_im;
                res1_re_q <= bus_io.i_bf_out1_re;
                res1_im_q <= bus_io.i_bf_out1_im;
            end
        end
    end

    // Data bank is intentionally left without reset.
    always_ff @(posedge i_clk) begin
        if (state_q == StLoad && bus_io.i_load_valid) begin
            bank_re[bitrev4(cnt_q)] <= bus_io.i_load_re;
            bank_im[bitrev4(cnt_q)] <= bus_io.i_load_im;
        end else if (state_q == StWrite) begin
            bank_re[idx0] <= res0_re_q;
            bank_im[idx0] <= res0_im_q;
            bank_re[idx1] <= res1_re_q;
            bank_im[idx1] <= res1_im_q;
        end
    end

    assign bus_io.o_load_ready = (state_q == StLoad);
    assign bus_io.o_busy       = (state_q != StLoad);
    assign bus_io.o_out_valid  = (state_q == StUnload);
    assign bus_io.o_out_re     = bank_re[cnt_q];
    assign bus_io.o_out_im     = bank_im[cnt_q];
    assign bus_io.o_out_index  = cnt_q;

    assign bus_io.o_bf_in0_re = in0_re_q;
    assign bus_io.o_bf_in0_im = in0_im_q;
    assign bus_io.o_bf_in1_re = in1_re_q;
    assign bus_io.o_bf_in1_im = in1_im_q;
    assign bus_io.o_bf_tw_re  = tw_re_q;
    assign bus_io.o_bf_tw_im  = tw_im_q;
endmodule

// File: tb/tb_fft16_sequencer.sv
// Directed bench: impulse, DC and ramp transforms through a reference butterfly responder,
// unload back-pressure, spurious done pulses and mid-transform reset.
module tb_fft16_sequencer;
    import fft16_sequencer_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft16_sequencer_if #(.WORD_SIZE(W)) bus ();

    fft16_sequencer #(
        .WORD_SIZE(W),
        .FRACTION (8)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus_io(bus)
    );

    logic         model_done = 1'b0;
    logic         spur_done = 1'b0;
    logic [W-1:0] rsp0_re = '0, rsp0_im = '0, rsp1_re = '0, rsp1_im = '0;

    assign bus.i_bf_done    = model_done | spur_done;
    assign bus.i_bf_out0_re = rsp0_re;
    assign bus.i_bf_out0_im = rsp0_im;
    assign bus.i_bf_out1_re = rsp1_re;
    assign bus.i_bf_out1_im = rsp1_im;

    int checks = 0;
    int failures = 0;

    // Reference bank: what the DUT bank should hold, in bank address order.
    logic [W-1:0] mb_re [16];
    logic [W-1:0] mb_im [16];
    int tw_re_t [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int tw_im_t [8] = '{0, -98, -181, -237, -256, -237, -181, -98};
    int br      [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    int present_cnt = 0;
    int cd = 0;
    int cur_p = 0;

    int zeros [16];
    int imp_re [16];
    int dc_re [16];
    int ramp_re [16];
    int ramp_im [16];
    int exp_imp_re [16];
    int exp_dc_re [16];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] ops_now();
        return {bus.o_bf_in0_re, bus.o_bf_in0_im, bus.o_bf_in1_re, bus.o_bf_in1_im,
                bus.o_bf_tw_re, bus.o_bf_tw_im};
    endfunction

    task automatic respond(input int p);
        int s, b, span, i0, i1, k, ar, ai, xr, xi, wr, wi, tr, ti;
        s    = p / 8;
        b    = p % 8;
        span = 1 << s;
        i0   = (b >> s) * 2 * span + (b % span);
        i1   = i0 + span;
        k    = (b % span) << (3 - s);
        check_eq($sformatf("ops p%0d", p), ops_now(),
                 {mb_re[i0], mb_im[i0], mb_re[i1], mb_im[i1], W'(tw_re_t[k]), W'(tw_im_t[k])});
        if (p == 0)
            check_eq("s0b0 idx0,1 tw", ops_now(),
                     {mb_re[0], mb_im[0], mb_re[1], mb_im[1], W'(256), W'(0)});
        if (p == 11)
            check_eq("s1b3 idx5,7 tw", ops_now(),
                     {mb_re[5], mb_im[5], mb_re[7], mb_im[7], W'(0), W'(-256)});
        if (p == 29)
            check_eq("s3b5 idx5,13 tw", ops_now(),
                     {mb_re[5], mb_im[5], mb_re[13], mb_im[13], W'(-98), W'(-237)});
        ar = int'($signed(mb_re[i0]));
        ai = int'($signed(mb_im[i0]));
        xr = int'($signed(mb_re[i1]));
        xi = int'($signed(mb_im[i1]));
        wr = tw_re_t[k];
        wi = tw_im_t[k];
        tr = (xr * wr - xi * wi) >>> 8;
        ti = (xr * wi + xi * wr) >>> 8;
        rsp0_re = W'(ar + tr);
        rsp0_im = W'(ai + ti);
        rsp1_re = W'(ar - tr);
        rsp1_im = W'(ai - ti);
        mb_re[i0] = rsp0_re;
        mb_im[i0] = rsp0_im;
        mb_re[i1] = rsp1_re;
        mb_im[i1] = rsp1_im;
        model_done = 1'b1;
    endtask

    // Butterfly responder: done three cycles after each PRESENT.
    initial begin
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!rst_n) cd = 0;
            else if (dut.state_q == StPresent) begin
                cur_p = present_cnt;
                present_cnt++;
                cd = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && cur_p < 32) respond(cur_p);
            end
        end
    end

    task automatic load_frame(input int xr [16], input int xi [16], input bit with_gap);
        int n;
        bit gap_done;
        n = 0;
        gap_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mb_re[br[i]] = W'(xr[i]);
            mb_im[br[i]] = W'(xi[i]);
        end
        present_cnt = 0;
        check_eq("load_ready in LOAD", bus.o_load_ready, 1'b1);
        while (n < 16) begin
            if (with_gap && n == 5 && !gap_done) begin
                bus.i_load_valid = 1'b0;
                bus.i_load_re = 16'h7777;
                spur_done = 1'b1;
                gap_done = 1'b1;
                @(negedge clk);
                spur_done = 1'b0;
            end else begin
                bus.i_load_valid = 1'b1;
                bus.i_load_re = W'(xr[n]);
                bus.i_load_im = W'(xi[n]);
                @(negedge clk);
                n++;
            end
        end
        bus.i_load_valid = 1'b0;
    endtask

    task automatic unload_check(input int er [16], input int ei [16], input bit use_model,
                                input bit stall);
        int guard;
        logic [W-1:0] xr [16];
        logic [W-1:0] xi [16];
        guard = 0;
        bus.i_out_ready = 1'b1;
        while (!bus.o_out_valid && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reached UNLOAD", bus.o_out_valid, 1'b1);
        check_eq("present count", present_cnt, 32);
        for (int i = 0; i < 16; i++) begin
            xr[i] = use_model ? mb_re[i] : W'(er[i]);
            xi[i] = use_model ? mb_im[i] : W'(ei[i]);
        end
        for (int i = 0; i < 16; i++) begin
            if (stall && i == 4) begin
                bus.i_out_ready = 1'b0;
                spur_done = 1'b1;
                @(negedge clk);
                spur_done = 1'b0;
                repeat (4) @(negedge clk);
                bus.i_out_ready = 1'b1;
            end
            check_eq($sformatf("out%0d", i), {bus.o_out_valid, bus.o_out_index, bus.o_out_re,
                     bus.o_out_im}, {1'b1, 4'(i), xr[i], xi[i]});
            @(negedge clk);
        end
        check_eq("back to LOAD", {bus.o_busy, bus.o_out_valid, bus.o_load_ready}, 3'b001);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 16; i++) begin
            zeros[i]      = 0;
            imp_re[i]     = (i == 0) ? 256 : 0;
            dc_re[i]      = 256;
            ramp_re[i]    = i * 16 - 100;
            ramp_im[i]    = (i * 7) % 23 - 11;
            exp_imp_re[i] = 256;
            exp_dc_re[i]  = (i == 0) ? 4096 : 0;
        end
        bus.i_load_valid = 1'b0;
        bus.i_load_re = '0;
        bus.i_load_im = '0;
        bus.i_out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("reset outputs", {bus.o_busy, bus.o_out_valid, ops_now()}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post-reset ready/index", {bus.o_load_ready, bus.o_out_index}, 5'h10);

        load_frame(imp_re, zeros, 1'b1);
        unload_check(exp_imp_re, zeros, 1'b0, 1'b1);

        load_frame(dc_re, zeros, 1'b0);
        unload_check(exp_dc_re, zeros, 1'b0, 1'b0);

        load_frame(ramp_re, ramp_im, 1'b0);
        unload_check(zeros, zeros, 1'b1, 1'b0);

        // Abort in stage 2 WAIT, then a fresh impulse must still come out right.
        load_frame(imp_re, zeros, 1'b0);
        guard = 0;
        while (!(present_cnt >= 18 && dut.state_q == StWait) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("reached stage2 WAIT", dut.state_q, StWait);
        rst_n = 1'b0;
        #1;
        check_eq("reset abort", {bus.o_busy, bus.o_load_ready, bus.o_out_valid, ops_now()},
                 {3'b010, 96'h0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("after abort ready", {bus.o_busy, bus.o_load_ready}, 2'b01);
        load_frame(imp_re, zeros, 1'b0);
        unload_check(exp_imp_re, zeros, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
